// File: rtl/tcam_lookup_arbiter.sv
// Round-robin front end for a shared TCAM search port.
// Accepts at most one search per cycle from PORTS clients, tracks the
// in-flight searches with a fixed-latency tag pipeline and steers each
// match result back to the client that issued it.
module tcam_lookup_arbiter #(
  parameter int PORTS          = 4,
  parameter int KEY_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int LOOKUP_LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS*KEY_WIDTH-1:0] req_key,
  input  logic [PORTS-1:0]           req_valid,
  output logic [PORTS-1:0]           req_ready,
  output logic [KEY_WIDTH-1:0]       tcam_search_key,
  output logic                       tcam_search_valid,
  input  logic                       tcam_match_valid,
  input  logic [ADDR_WIDTH-1:0]      tcam_match_addr,
  output logic [PORTS-1:0]           resp_valid,
  output logic                       resp_match,
  output logic [ADDR_WIDTH-1:0]      resp_addr,
  input  logic                       cfg_busy,
  output logic                       cfg_idle,
  output logic [31:0]                stat_lookups
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  // Round-robin pointer: index of the most recently granted port.
  logic [IDX_W-1:0]     ptr;

  logic [PORTS-1:0]     eligible;
  logic [PORTS-1:0]     grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     hi_idx;
  logic [IDX_W-1:0]     lo_idx;
  logic                 found_hi;
  logic                 found_lo;
  logic                 transfer;
  logic [KEY_WIDTH-1:0] sel_key;

  // Search stage (_p0) travels with tcam_search_valid; lookup stages (_p1)
  // cover the TCAM latency, the tail lining up with tcam_match_*.
  logic [IDX_W-1:0]          tag_p0;
  logic [LOOKUP_LATENCY-1:0] vld_p1;
  logic [IDX_W-1:0]          tag_p1 [LOOKUP_LATENCY];

  logic                 tail_vld;
  logic [IDX_W-1:0]     tail_tag;
  logic [PORTS-1:0]     resp_onehot;

  // Arbitration: first eligible port above the pointer, else wrap to the lowest.
  always_comb begin
    eligible  = req_valid & {PORTS{~cfg_busy & ~rst}};
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (eligible[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = IDX_W'(i);
      end
      if (eligible[i] && (i > int'(ptr)) && !found_hi) begin
        found_hi = 1'b1;
        hi_idx   = IDX_W'(i);
      end
    end
    grant_idx = found_hi ? hi_idx : lo_idx;
    grant     = '0;
    sel_key   = '0;
    for (int i = 0; i < PORTS; i++) begin
      grant[i] = found_lo && (grant_idx == IDX_W'(i));
      if (grant[i]) sel_key = req_key[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;

  // ---- stage p0: accepted search launched to the TCAM ----
  // Search strobe, key, pointer and lookup counter update on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcam_search_valid <= 1'b0;
      tcam_search_key   <= '0;
      ptr               <= IDX_W'(PORTS - 1);
      stat_lookups      <= '0;
    end else begin
      tcam_search_valid <= transfer;
      if (transfer) begin
        tcam_search_key <= sel_key;
        ptr             <= grant_idx;
        stat_lookups    <= stat_lookups + 32'd1;
      end
    end
  end

  // Owner tag rides alongside the search strobe.
  always_ff @(posedge clk) begin
    if (transfer) tag_p0 <= grant_idx;
  end

  // ---- stage p1: tag pipeline covering the TCAM lookup latency ----
  // Valid bits shift every cycle and are cleared by reset to drop in-flight searches.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= tcam_search_valid;
      for (int k = 1; k < LOOKUP_LATENCY; k++) vld_p1[k] <= vld_p1[k-1];
    end
  end

  // Owner tags shift in lockstep with the valid bits.
  always_ff @(posedge clk) begin
    tag_p1[0] <= tag_p0;
    for (int k = 1; k < LOOKUP_LATENCY; k++) tag_p1[k] <= tag_p1[k-1];
  end

  assign tail_vld = vld_p1[LOOKUP_LATENCY-1];
  assign tail_tag = tag_p1[LOOKUP_LATENCY-1];

  // Decode the owning port of the search whose result is on tcam_match_*.
  always_comb begin
    resp_onehot = '0;
    for (int i = 0; i < PORTS; i++) resp_onehot[i] = (tail_tag == IDX_W'(i));
  end

  // ---- stage p2: registered response to the owning port ----
  // One-cycle pulse; the address is forced to zero on a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_match <= 1'b0;
      resp_addr  <= '0;
    end else begin
      resp_valid <= tail_vld ? resp_onehot : '0;
      resp_match <= tail_vld & tcam_match_valid;
      resp_addr  <= (tail_vld && tcam_match_valid) ? tcam_match_addr : '0;
    end
  end

  assign cfg_idle = ~tcam_search_valid & ~(|vld_p1) & ~(|resp_valid);

endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Directed bench for tcam_lookup_arbiter with a small fixed-latency TCAM model.
// TCAM model: a key whose low byte is 0xFF misses (address bus shows 0x3F);
// any other key hits at address key[5:0] ^ 6'h2A.
module tb_tcam_lookup_arbiter;

  localparam int PORTS = 4;
  localparam int KW    = 32;
  localparam int AW    = 6;
  localparam int LAT   = 2;

  logic                  clk;
  logic                  rst;
  logic [PORTS*KW-1:0]   req_key;
  logic [PORTS-1:0]      req_valid;
  logic [PORTS-1:0]      req_ready;
  logic [KW-1:0]         tcam_search_key;
  logic                  tcam_search_valid;
  logic                  tcam_match_valid;
  logic [AW-1:0]         tcam_match_addr;
  logic [PORTS-1:0]      resp_valid;
  logic                  resp_match;
  logic [AW-1:0]         resp_addr;
  logic                  cfg_busy;
  logic                  cfg_idle;
  logic [31:0]           stat_lookups;

  int n_vec  = 0;
  int n_miss = 0;

  logic          m_vld [LAT];
  logic [KW-1:0] m_key [LAT];

  // Hit addresses for the keys {24'hA5A5A5, 8'h10+p}, worked out by hand.
  logic [AW-1:0] exp_addr [PORTS] = '{6'h3A, 6'h3B, 6'h38, 6'h39};

  tcam_lookup_arbiter #(
    .PORTS(PORTS), .KEY_WIDTH(KW), .ADDR_WIDTH(AW), .LOOKUP_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_key(req_key), .req_valid(req_valid),
    .req_ready(req_ready), .tcam_search_key(tcam_search_key),
    .tcam_search_valid(tcam_search_valid), .tcam_match_valid(tcam_match_valid),
    .tcam_match_addr(tcam_match_addr), .resp_valid(resp_valid),
    .resp_match(resp_match), .resp_addr(resp_addr), .cfg_busy(cfg_busy),
    .cfg_idle(cfg_idle), .stat_lookups(stat_lookups)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < LAT; k++) begin
      m_vld[k] = 1'b0;
      m_key[k] = '0;
    end
  end

  always @(posedge clk) begin
    m_vld[0] <= tcam_search_valid;
    m_key[0] <= tcam_search_key;
    for (int k = 1; k < LAT; k++) begin
      m_vld[k] <= m_vld[k-1];
      m_key[k] <= m_key[k-1];
    end
  end

  always_comb begin
    tcam_match_valid = m_vld[LAT-1] && (m_key[LAT-1][7:0] != 8'hFF);
    tcam_match_addr  = tcam_match_valid ? (m_key[LAT-1][5:0] ^ 6'h2A) : 6'h3F;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t2_keys();
    for (int p = 0; p < PORTS; p++) req_key[p*KW +: KW] = {24'hA5A5A5, 8'(8'h10 + p)};
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_key   = '0;
    cfg_busy  = 1'b0;

    // Reset: no grant even with all requests high, outputs at reset values.
    next_cyc();
    req_valid = '1;
    #1 chk("rst_ready", 32'(req_ready), 32'h0);
    next_cyc();
    chk("rst_search_valid", 32'(tcam_search_valid), 32'h0);
    chk("rst_search_key",   tcam_search_key,        32'h0);
    chk("rst_resp_valid",   32'(resp_valid),        32'h0);
    chk("rst_resp_match",   32'(resp_match),        32'h0);
    chk("rst_resp_addr",    32'(resp_addr),         32'h0);
    chk("rst_stat",         stat_lookups,           32'h0);
    chk("rst_cfg_idle",     32'(cfg_idle),          32'h1);
    req_valid = '0;
    rst       = 1'b0;

    // Single search from port 2, hit at address 5.
    next_cyc();
    req_valid = 4'b0100;
    req_key[2*KW +: KW] = 32'hDEADBEEF;
    #1 chk("t1_ready", 32'(req_ready), 32'h4);
    next_cyc();
    req_valid = '0;
    chk("t1_search_valid", 32'(tcam_search_valid), 32'h1);
    chk("t1_search_key",   tcam_search_key,        32'hDEADBEEF);
    chk("t1_stat",         stat_lookups,           32'h1);
    next_cyc();
    chk("t1_resp_t2", 32'(resp_valid), 32'h0);
    next_cyc();
    chk("t1_resp_t3", 32'(resp_valid), 32'h0);
    next_cyc();
    chk("t1_resp_valid", 32'(resp_valid), 32'h4);
    chk("t1_resp_match", 32'(resp_match), 32'h1);
    chk("t1_resp_addr",  32'(resp_addr),  32'h5);
    next_cyc();
    chk("t1_resp_end", 32'(resp_valid), 32'h0);
    chk("t1_idle",     32'(cfg_idle),   32'h1);

    // Two searches in flight (ports 3 then 1), then a one-cycle reset.
    req_valid = 4'b1010;
    req_key[1*KW +: KW] = 32'h0000_0001;
    req_key[3*KW +: KW] = 32'h0000_0003;
    #1 chk("t5_ready_a", 32'(req_ready), 32'h8);
    next_cyc();
    #1 chk("t5_ready_b", 32'(req_ready), 32'h2);
    next_cyc();
    req_valid = '0;
    rst       = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk("t5_stat", stat_lookups, 32'h0);
    for (int c = 0; c < 5; c++) begin
      chk("t5_no_resp", 32'(resp_valid), 32'h0);
      next_cyc();
    end

    // All four ports requesting for 8 cycles: grants 0,1,2,3,0,1,2,3.
    set_t2_keys();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) next_cyc();
      if (c >= 4 && c < 12) begin
        chk("t2_resp_valid", 32'(resp_valid), 32'(1 << ((c - 4) % 4)));
        chk("t2_resp_match", 32'(resp_match), 32'h1);
        chk("t2_resp_addr",  32'(resp_addr),  32'(exp_addr[(c - 4) % 4]));
      end else begin
        chk("t2_resp_idle", 32'(resp_valid), 32'h0);
      end
      if (c >= 1 && c <= 8)
        chk("t2_search_key", tcam_search_key, {24'hA5A5A5, 8'(8'h10 + ((c - 1) % 4))});
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1 chk("t2_ready", 32'(req_ready), (c < 8) ? 32'(1 << (c % 4)) : 32'h0);
    end
    next_cyc();
    chk("t2_stat", stat_lookups, 32'd8);

    // Ports 1 and 3 alternate; keys miss so match and address read zero.
    req_key[1*KW +: KW] = 32'h1111_11FF;
    req_key[3*KW +: KW] = 32'h3333_33FF;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cyc();
      if (c >= 4 && c < 8) begin
        chk("t3_resp_valid", 32'(resp_valid), ((c % 2) == 0) ? 32'h2 : 32'h8);
        chk("t3_resp_match", 32'(resp_match), 32'h0);
        chk("t3_resp_addr",  32'(resp_addr),  32'h0);
      end else begin
        chk("t3_resp_idle", 32'(resp_valid), 32'h0);
      end
      req_valid = (c < 4) ? 4'b1010 : 4'b0000;
      #1 chk("t3_ready", 32'(req_ready),
             (c < 4) ? (((c % 2) == 0) ? 32'h2 : 32'h8) : 32'h0);
    end
    chk("t3_stat", stat_lookups, 32'd12);

    // Three searches (ports 0,1,2), then cfg_busy for cycles 3..9.
    set_t2_keys();
    next_cyc();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cyc();
      if (c >= 4 && c <= 6) begin
        chk("t4_resp_valid", 32'(resp_valid), 32'(1 << (c - 4)));
        chk("t4_resp_match", 32'(resp_match), 32'h1);
        chk("t4_resp_addr",  32'(resp_addr),  32'(exp_addr[c - 4]));
      end else begin
        chk("t4_resp_idle", 32'(resp_valid), 32'h0);
      end
      if (c >= 3)
        chk("t4_cfg_idle", 32'(cfg_idle), (c >= 7 && c <= 10) ? 32'h1 : 32'h0);
      if (c == 9)
        chk("t4_stat_busy", stat_lookups, 32'd15);
      cfg_busy  = (c >= 3 && c < 10);
      req_valid = (c < 3) ? 4'b0111 : ((c <= 10) ? 4'b1111 : 4'b0000);
      #1 chk("t4_ready", 32'(req_ready),
             (c < 3) ? 32'(1 << c) : ((c == 10) ? 32'h8 : 32'h0));
    end
    chk("t4_stat", stat_lookups, 32'd16);

    repeat (6) next_cyc();
    chk("final_idle", 32'(cfg_idle), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
